// File: rtl/picovid_pkg.sv
// Shared types and constants for the picovid capture-channel poller.
package picovid_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BYTE    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [2:0] PADD_IDLE = 3'd7;
    localparam logic [2:0] PADD_ACK  = 3'd0;

    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 16;
    localparam int POLL_LEN = 5;

    // Address 0 releases the capture device, so it is always read last.
    localparam logic [2:0] POLL_SEQ [0:POLL_LEN-1] = '{3'd1, 3'd2, 3'd3, 3'd4, PADD_ACK};
    localparam logic [2:0] IDX_LAST = 3'(POLL_LEN - 1);

endpackage

// File: rtl/picovid_sync.sv
// Two-flop synchronizer for the open-drain ready line; idles high like the pull-up.
module picovid_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/picovid_poller.sv
// Polls a latched 68k write out of the picovid capture device byte by byte and
// presents it as a single-entry valid/ready record stream.
module picovid_poller
    import picovid_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rts_n,
    input  logic [7:0]        poll_d,
    output logic [2:0]        padd,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [DATA_W-1:0] rec_data,
    output logic              busy,
    output logic              err_timeout,
    output logic [1:0]        dbg_state
);

    // Stream handshake: a record transfers on any cycle where rec_valid and
    // rec_ready are both high; rec_valid and the record stay stable until then.

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_t          state;
    logic            rts_s;
    logic [7:0]      poll_q;
    logic [2:0]      idx;
    logic [SW-1:0]   settle_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      addr_hi, addr_mid, addr_lo, data_hi, data_lo;

    picovid_sync u_rts_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (rts_n),
        .q     (rts_s)
    );

    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            padd        <= PADD_IDLE;
            rec_valid   <= 1'b0;
            rec_addr    <= '0;
            rec_data    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            poll_q      <= '0;
            idx         <= '0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            addr_hi     <= '0;
            addr_mid    <= '0;
            addr_lo     <= '0;
            data_hi     <= '0;
            data_lo     <= '0;
        end else begin
            poll_q <= poll_d;

            if (rec_valid && rec_ready) begin
                rec_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    padd <= PADD_IDLE;
                    // Registered rec_valid: a consumed record frees the slot one cycle later.
                    if (!rts_s && !rec_valid) begin
                        state      <= BYTE;
                        idx        <= '0;
                        settle_cnt <= '0;
                        padd       <= POLL_SEQ[0];
                        busy       <= 1'b1;
                    end
                end

                BYTE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        case (padd)
                            3'd1:    addr_mid <= poll_q;
                            3'd2:    addr_lo  <= poll_q;
                            3'd3:    data_hi  <= poll_q;
                            3'd4:    data_lo  <= poll_q;
                            default: addr_hi  <= poll_q;
                        endcase
                        if (idx != IDX_LAST) begin
                            idx  <= idx + 3'd1;
                            padd <= POLL_SEQ[idx + 3'd1];
                        end else begin
                            state   <= RELEASE;
                            tmo_cnt <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    // Waiting for rts_s high keeps the stale low level from re-triggering a poll.
                    if (rts_s || (tmo_cnt == TIMEOUT_LAST)) begin
                        if (!rts_s) begin
                            err_timeout <= 1'b1;
                        end
                        padd      <= PADD_IDLE;
                        rec_addr  <= {addr_hi, addr_mid, addr_lo[7:1], 1'b0};
                        rec_data  <= {data_hi, data_lo};
                        rec_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    padd  <= PADD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/picovid_poller.md
# picovid_poller

Host-side receiver for the picovid capture channel. The capture CPLD latches one 68k bus write (24-bit address, 16-bit data) and pulls an open-drain ready line low. It then presents the latched bytes on an 8-bit bus selected by a 3-bit poll address, and releases the line when poll address 0 is driven. This block watches the ready line, walks the poll address, reassembles the record, acknowledges it, and hands it downstream on a valid/ready stream.

## Interface
Parameters:
- SETTLE, default 4: cycles each poll address is held before its byte is sampled; minimum 2.
- TIMEOUT, default 255: cycles allowed in RELEASE for the ready line to go high.

Ports:
- CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- rts_n  in  1  capture ready line; open-drain, externally pulled up; low = record pending.
- poll_d  in  8  byte bus from the capture device.
- padd  out  3  poll address; 7 = idle, capture bus tri-stated.
- rec_valid  out  1  record available.
- rec_ready  in  1  downstream accepts the record.
- rec_addr  out  24  captured address; bit 0 is always 0.
- rec_data  out  16  captured data.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky; cleared only by RESET.

## Operation
- rts_n passes through a 2-flop synchronizer giving rts_s. poll_d is registered once as poll_q before use.
- Byte order is 1, 2, 3, 4, then 0. Poll address 0 acknowledges the capture device, so it must come last; all other bytes must be read while the record is still held.
  - 1 → addr[15:8]
  - 2 → addr[7:0]
  - 3 → data[15:8]
  - 4 → data[7:0]
  - 0 → addr[23:16]
- State machine:
  - IDLE: padd=7. Move to BYTE, idx=0, when rts_s==0 and rec_valid==0.
  - BYTE: padd = seq[idx], where seq = {1,2,3,4,0}. A settle counter runs 0..SETTLE-1. On terminal count, load poll_q into the matching shadow byte. If idx<4, increment idx; otherwise go to RELEASE.
  - RELEASE: padd held at 0; timeout counter runs.
    - rts_s==1: padd=7, load shadows into rec_addr/rec_data, set rec_valid, go to IDLE.
    - Counter reaches TIMEOUT first: same actions, plus set err_timeout.
- Output register: single entry. It clears when rec_valid && rec_ready. No new poll starts while rec_valid=1.
  - This stalls the capture device. Further 68k writes are dropped by the capture device; this is accepted.
- Reset values: padd=7, rec_valid=0, rec_addr=0, rec_data=0, busy=0, err_timeout=0. Shadows, counters and idx are all 0; state is IDLE.
- Reset mid-poll: abandons the sequence and returns padd to 7. Because the capture device still holds the record with rts_n low, the next poll re-reads it in full. No record is lost or duplicated.

## Timing
- padd is registered and changes on the edge that enters or advances the BYTE step.
- Each BYTE step takes SETTLE cycles. poll_q is sampled SETTLE cycles after padd changes, so ≥1 cycle of settle is absorbed by the input register.
- Detection latency: rts_n falling to first padd change is 3 cycles (2 synchronizer cycles plus 1 state cycle).
- Full record: 3 + 5·SETTLE + release wait + 1 cycles to rec_valid. With SETTLE=4 and a 3-cycle release, that is 27 cycles.
- rts_n must be seen high (synchronized) before returning to IDLE. This prevents the stale low level from triggering a double poll.
- rec_valid and rec_ready both high in the same cycle: record consumed. A new poll may begin the following cycle if rts_s==0.
- RESET overrides all other events in the same cycle.

## Structure
- Package picovid_pkg holds:
  - state enum {IDLE, BYTE, RELEASE}
  - PADD_IDLE=3'd7 and PADD_ACK=3'd0
  - the 5-entry poll sequence constant
  - the record width constants (24/16)
- Sub-module picovid_sync: a 2-flop synchronizer with reset value 1, instantiated for rts_n.

## Test plan
- Basic: capture model holds addr 0x3ABCDE / data 0x1234 and drops rts_n. Required:
  - padd sequence 7,1,2,3,4,0,7 with each value held SETTLE cycles
  - rec_addr=0x3ABCDE, rec_data=0x1234, one rec_valid pulse held until rec_ready
- Backpressure: rec_ready=0 while a second record (0x300002 / 0xBEEF) is pending. Required:
  - padd stays 7 until the first record is accepted
  - the second record then arrives intact
- Timeout: the model never releases rts_n after padd=0. Required:
  - after TIMEOUT cycles, err_timeout=1 and the record is delivered
  - err_timeout persists until RESET
- Reset mid-poll: assert RESET at idx=2. Required:
  - padd=7 next cycle and outputs at reset values
  - after release, a full re-poll delivers the original record exactly once
- Back-to-back: three records 0x300000/0x0001, 0x300004/0x0002, 0x300008/0x0003 with rec_ready tied high. Required:
  - all three delivered in order
  - no poll starts before rts_s is seen high between records
